// File: rtl/usb_token_rx_ctrl.sv
// usb_token_rx_ctrl
// Receive-side sequencer for USB token packets (OUT/IN/SETUP/SOF). It takes the
// PID byte and the two payload bytes from the byte receiver and checks the PID.
// It then stalls the receiver while the 16 payload bits go LSB-first through a
// serial CRC5 LFSR. For each packet it reports exactly one outcome pulse: good
// token, malformed token, or token dropped by the address filter.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data/valid       received byte (bit 0 first on the wire) and its qualifier
//   rx_sop/rx_eop       first (PID) / last byte of a packet
//   rx_ready            byte accepted when rx_valid & rx_ready
//   busy                controller is not idle
//   tok_valid/err/drop  one-cycle outcome pulses
//   tok_pid/addr/endp   fields of the last good or dropped token
//                       (for SOF, addr/endp hold frame[6:0]/frame[10:7])
module usb_token_rx_ctrl #(
  parameter logic [4:0] CRC_RESIDUE    = 5'b01100,
  parameter logic       ADDR_FILTER_EN = 1'b0,
  parameter logic [6:0] DEV_ADDR       = 7'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_sop,
  input  logic       rx_eop,
  output logic       rx_ready,
  output logic       busy,
  output logic       tok_valid,
  output logic       tok_err,
  output logic       tok_drop,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp
);

  typedef enum logic [2:0] {S_IDLE, S_PID_OK, S_BYTE1, S_CRC, S_REPORT} state_t;

  localparam logic [3:0] PID_SOF = 4'b0101;

  state_t     state_q, state_d;
  logic [4:0] lfsr_q, lfsr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [3:0] pid_q;
  logic [7:0] byte1_q, byte2_q;
  logic [3:0] tok_pid_q;
  logic [6:0] tok_addr_q;
  logic [3:0] tok_endp_q;

  logic        accept;
  logic        pid_chk_ok;
  logic [15:0] payload;
  logic        is_report;
  logic        rpt_fail;
  logic        rpt_filtered;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = c[4] ^ b;
    return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  function automatic logic is_token_pid(input logic [3:0] pid);
    return (pid == 4'b0001) || (pid == 4'b1001) || (pid == 4'b1101) || (pid == 4'b0101);
  endfunction

  assign rx_ready   = (state_q == S_IDLE) || (state_q == S_PID_OK) || (state_q == S_BYTE1);
  assign busy       = (state_q != S_IDLE);
  assign accept     = rx_valid & rx_ready;
  assign pid_chk_ok = (rx_data[7:4] == ~rx_data[3:0]);
  assign payload    = {byte2_q, byte1_q};

  // The outcome is resolved in REPORT from the held LFSR, PID and byte1, so
  // the three pulses are mutually exclusive by construction.
  assign is_report    = (state_q == S_REPORT);
  assign rpt_fail     = err_q || (lfsr_q != CRC_RESIDUE);
  assign rpt_filtered = ADDR_FILTER_EN && (pid_q != PID_SOF) && (byte1_q[6:0] != DEV_ADDR);
  assign tok_err      = is_report && rpt_fail;
  assign tok_drop     = is_report && !rpt_fail && rpt_filtered;
  assign tok_valid    = is_report && !rpt_fail && !rpt_filtered;

  assign tok_pid  = tok_pid_q;
  assign tok_addr = tok_addr_q;
  assign tok_endp = tok_endp_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        // Non-token PIDs that pass the check leave us in IDLE, so the rest of
        // that packet is discarded for lack of rx_sop.
        if (accept && rx_sop) begin
          if (!pid_chk_ok) begin
            err_d   = 1'b1;
            state_d = S_REPORT;
          end else if (is_token_pid(rx_data[3:0])) begin
            err_d   = 1'b0;
            state_d = S_PID_OK;
          end
        end
      end
      S_PID_OK: begin
        if (accept) begin
          if (rx_sop || rx_eop) begin
            err_d   = 1'b1;
            state_d = S_REPORT;
          end else begin
            state_d = S_BYTE1;
          end
        end
      end
      S_BYTE1: begin
        if (accept) begin
          if (rx_sop || !rx_eop) begin
            err_d   = 1'b1;
            state_d = S_REPORT;
          end else begin
            lfsr_d  = 5'b11111;
            cnt_d   = 4'd0;
            state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        lfsr_d = crc5_step(lfsr_q, payload[cnt_q]);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 5'b11111;
      cnt_q      <= 4'd0;
      err_q      <= 1'b0;
      tok_pid_q  <= 4'd0;
      tok_addr_q <= 7'd0;
      tok_endp_q <= 4'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (is_report && !rpt_fail) begin
        tok_pid_q  <= pid_q;
        tok_addr_q <= byte1_q[6:0];
        tok_endp_q <= {byte2_q[2:0], byte1_q[7]};
      end
    end
  end

  // Packet bytes are pure data; they are only read after being written.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && accept && rx_sop) begin
      pid_q <= rx_data[3:0];
    end
    if ((state_q == S_PID_OK) && accept && !rx_sop) begin
      byte1_q <= rx_data;
    end
    if ((state_q == S_BYTE1) && accept && !rx_sop) begin
      byte2_q <= rx_data;
    end
  end

endmodule

// File: tb/tb_usb_token_rx_ctrl.sv
module tb_usb_token_rx_ctrl;

  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_ERR   = 3'b010;
  localparam logic [2:0] K_DROP  = 3'b001;

  typedef struct {
    int         due;
    logic [2:0] k0;
    logic [2:0] k1;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sop, rx_eop;
  logic [1:0] rdy, bsy, tv, te, td;
  logic [3:0] tpid  [2];
  logic [6:0] taddr [2];
  logic [3:0] tendp [2];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];
  logic [3:0] fexp_pid  [2];
  logic [6:0] fexp_addr [2];
  logic [3:0] fexp_endp [2];
  logic pend_fields;
  int   v_cyc_prev, v_cyc_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_token_rx_ctrl #(.CRC_RESIDUE(5'b01100), .ADDR_FILTER_EN(1'b0), .DEV_ADDR(7'd0)) u_dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .rx_ready(rdy[0]), .busy(bsy[0]), .tok_valid(tv[0]), .tok_err(te[0]),
    .tok_drop(td[0]), .tok_pid(tpid[0]), .tok_addr(taddr[0]), .tok_endp(tendp[0])
  );

  usb_token_rx_ctrl #(.CRC_RESIDUE(5'b01100), .ADDR_FILTER_EN(1'b1), .DEV_ADDR(7'd5)) u_dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .rx_ready(rdy[1]), .busy(bsy[1]), .tok_valid(tv[1]), .tok_err(te[1]),
    .tok_drop(td[1]), .tok_pid(tpid[1]), .tok_addr(taddr[1]), .tok_endp(tendp[1])
  );

  // Reference LFSR: one bit per step, LSB-first over the 16 payload bits.
  function automatic logic [4:0] m_step(input logic [4:0] c, input logic b);
    logic [4:0] n;
    n = {c[3:0], 1'b0};
    if (c[4] ^ b) n = n ^ 5'b00101;
    return n;
  endfunction

  function automatic logic [4:0] m_lfsr16(input logic [15:0] p);
    logic [4:0] c;
    c = 5'b11111;
    for (int i = 0; i < 16; i++) c = m_step(c, p[i]);
    return c;
  endfunction

  // Find the CRC5 that makes the packet leave the expected residue.
  function automatic logic [7:0] m_byte2(input logic [10:0] data);
    logic [7:0] r;
    logic [4:0] crc;
    r = 8'h00;
    for (int k = 0; k < 32; k++) begin
      crc = k[4:0];
      if (m_lfsr16({crc, data}) == 5'b01100) r = {crc, data[10:8]};
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(input int lat, input logic [2:0] k0, input logic [2:0] k1,
                                  input logic [3:0] pid, input logic [6:0] addr,
                                  input logic [3:0] endp);
    exp_t e;
    e.due = lat; e.k0 = k0; e.k1 = k1; e.pid = pid; e.addr = addr; e.endp = endp;
    return e;
  endfunction

  function automatic logic [2:0] k_filt(input logic [3:0] pid, input logic [6:0] addr);
    return (pid != 4'b0101 && addr != 7'd5) ? K_DROP : K_VALID;
  endfunction

  // Presents a byte and holds it until accepted. When push is set, the
  // expectation is queued with due = acceptance cycle + e.due.
  task automatic send_byte(input logic [7:0] b, input logic sop, input logic eop,
                           input logic push, input exp_t e);
    exp_t ee;
    bit   done;
    rx_data = b; rx_sop = sop; rx_eop = eop; rx_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (rdy[0] === 1'b1) begin
        if (push) begin
          ee = e;
          ee.due = cyc + e.due;
          sbq.push_back(ee);
        end
        done = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL accept_timeout byte=%h rx_ready=%b want 1", b, rdy[0]);
    end
  endtask

  task automatic idle_bus();
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic send_tok(input logic [7:0] pidb, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [2:0] k0, input logic [2:0] k1, input logic push);
    exp_t e;
    e = mk_exp(17, k0, k1, pidb[3:0], b1[6:0], {b2[2:0], b1[7]});
    send_byte(pidb, 1'b1, 1'b0, 1'b0, e);
    send_byte(b1, 1'b0, 1'b0, 1'b0, e);
    send_byte(b2, 1'b0, 1'b1, push, e);
  endtask

  task automatic send_good(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                           input logic push);
    send_tok({~pid, pid}, {endp[0], addr}, m_byte2({endp, addr}), K_VALID, k_filt(pid, addr), push);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", sbq.size());
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t       e;
    logic [2:0] p0, p1;
    forever begin
      @(negedge clk);
      if (pend_fields) begin
        pend_fields = 1'b0;
        for (int d = 0; d < 2; d++) begin
          total++;
          if ({tpid[d], taddr[d], tendp[d]} !== {fexp_pid[d], fexp_addr[d], fexp_endp[d]}) begin
            bad++;
            $display("FAIL fields dut%0d got pid=%h addr=%h endp=%h want pid=%h addr=%h endp=%h",
                     d, tpid[d], taddr[d], tendp[d], fexp_pid[d], fexp_addr[d], fexp_endp[d]);
          end
        end
      end
      p0 = {tv[0], te[0], td[0]};
      p1 = {tv[1], te[1], td[1]};
      if (sbq.size() != 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        total++;
        if (p0 !== e.k0) begin
          bad++;
          $display("FAIL pulse dut0 cyc=%0d got vld/err/drop=%b want %b", cyc, p0, e.k0);
        end
        total++;
        if (p1 !== e.k1) begin
          bad++;
          $display("FAIL pulse dut1 cyc=%0d got vld/err/drop=%b want %b", cyc, p1, e.k1);
        end
        if (e.k0 == K_VALID || e.k0 == K_DROP) begin
          fexp_pid[0] = e.pid; fexp_addr[0] = e.addr; fexp_endp[0] = e.endp;
        end
        if (e.k1 == K_VALID || e.k1 == K_DROP) begin
          fexp_pid[1] = e.pid; fexp_addr[1] = e.addr; fexp_endp[1] = e.endp;
        end
        pend_fields = 1'b1;
        if (tv[0] === 1'b1) begin
          v_cyc_prev = v_cyc_last;
          v_cyc_last = cyc;
        end
      end else begin
        total++;
        if ({p0, p1} !== {K_NONE, K_NONE}) begin
          bad++;
          $display("FAIL spurious_pulse cyc=%0d got dut0=%b dut1=%b want 000", cyc, p0, p1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({rdy[d], bsy[d], tv[d], te[d], td[d]} !== 5'b10000) begin
        bad++;
        $display("FAIL reset_ctrl dut%0d got rdy/busy/v/e/d=%b want 10000",
                 d, {rdy[d], bsy[d], tv[d], te[d], td[d]});
      end
      total++;
      if ({tpid[d], taddr[d], tendp[d]} !== 15'd0) begin
        bad++;
        $display("FAIL reset_fields dut%0d got %h want 0", d, {tpid[d], taddr[d], tendp[d]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy, bsy} !== 4'b1100) begin
      bad++;
      $display("FAIL post_reset_idle got rdy=%b busy=%b want 11/00", rdy, bsy);
    end
  endtask

  task automatic test_setup();
    int n;
    send_tok(8'h2D, 8'h00, 8'h10, K_VALID, K_DROP, 1'b1);
    idle_bus();
    n = 0;
    while (rdy[0] !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 17) begin
      bad++;
      $display("FAIL ready_low_cycles got %0d want 17", n);
    end
    wait_drain();
    total++;
    if ({tpid[0], taddr[0], tendp[0]} !== {4'hD, 7'd0, 4'd0}) begin
      bad++;
      $display("FAIL setup_fields got pid=%h addr=%h endp=%h want d/0/0", tpid[0], taddr[0], tendp[0]);
    end
  endtask

  task automatic test_crc_err();
    send_tok(8'h2D, 8'h00, 8'h18, K_ERR, K_ERR, 1'b1);
    idle_bus();
    wait_drain();
    send_tok(8'hE1, 8'h85, m_byte2({4'd3, 7'd5}) ^ 8'h08, K_ERR, K_ERR, 1'b1);
    idle_bus();
    wait_drain();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({tpid[d], taddr[d], tendp[d]} !== {4'hD, 7'd0, 4'd0}) begin
        bad++;
        $display("FAIL crc_err_fields_kept dut%0d got pid=%h addr=%h endp=%h want d/0/0",
                 d, tpid[d], taddr[d], tendp[d]);
      end
    end
  endtask

  task automatic test_pid_err();
    exp_t e;
    e = mk_exp(1, K_ERR, K_ERR, 4'd0, 7'd0, 4'd0);
    send_byte(8'h2C, 1'b1, 1'b0, 1'b1, e);
    idle_bus();
    wait_drain();
    send_byte(8'hC3, 1'b1, 1'b0, 1'b0, e);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bsy !== 2'b00) begin
        bad++;
        $display("FAIL data_pkt_busy byte=%0d got %b want 00", i, bsy);
      end
      send_byte(8'h11 * (i + 1), 1'b0, (i == 3), 1'b0, e);
    end
    total++;
    if (bsy !== 2'b00) begin
      bad++;
      $display("FAIL data_pkt_busy_end got %b want 00", bsy);
    end
    idle_bus();
    wait_drain();
  endtask

  task automatic test_filter();
    send_tok(8'h69, 8'h00, 8'h10, K_VALID, K_DROP, 1'b1);
    send_tok(8'hA5, 8'hC3, m_byte2(11'h5C3), K_VALID, K_VALID, 1'b1);
    send_good(4'b0001, 7'd5, 4'hA, 1'b1);
    idle_bus();
    wait_drain();
  endtask

  task automatic test_malformed();
    exp_t e, none;
    e    = mk_exp(1, K_ERR, K_ERR, 4'd0, 7'd0, 4'd0);
    none = mk_exp(0, K_NONE, K_NONE, 4'd0, 7'd0, 4'd0);
    // eop on byte1
    send_byte(8'hE1, 1'b1, 1'b0, 1'b0, none);
    send_byte(8'h85, 1'b0, 1'b1, 1'b1, e);
    idle_bus();
    wait_drain();
    // byte2 without eop, then a trailing byte that must be discarded
    send_byte(8'hE1, 1'b1, 1'b0, 1'b0, none);
    send_byte(8'h85, 1'b0, 1'b0, 1'b0, none);
    send_byte(m_byte2({4'd3, 7'd5}), 1'b0, 1'b0, 1'b1, e);
    send_byte(8'h00, 1'b0, 1'b1, 1'b0, none);
    idle_bus();
    wait_drain();
    // new sop while in BYTE1; following bytes would form a SETUP if reused
    send_byte(8'hE1, 1'b1, 1'b0, 1'b0, none);
    send_byte(8'h85, 1'b0, 1'b0, 1'b0, none);
    send_byte(8'h2D, 1'b1, 1'b0, 1'b1, e);
    send_byte(8'h00, 1'b0, 1'b0, 1'b0, none);
    send_byte(8'h10, 1'b0, 1'b1, 1'b0, none);
    idle_bus();
    wait_drain();
    // new sop while in PID_OK
    send_byte(8'hE1, 1'b1, 1'b0, 1'b0, none);
    send_byte(8'h69, 1'b1, 1'b0, 1'b1, e);
    idle_bus();
    wait_drain();
  endtask

  task automatic test_rst_mid_crc();
    send_good(4'b1001, 7'd33, 4'h6, 1'b0);
    idle_bus();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend_fields = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fexp_pid[d] = 4'd0; fexp_addr[d] = 7'd0; fexp_endp[d] = 4'd0;
      total++;
      if ({rdy[d], bsy[d]} !== 2'b10) begin
        bad++;
        $display("FAIL rst_mid_state dut%0d got rdy=%b busy=%b want 1/0", d, rdy[d], bsy[d]);
      end
      total++;
      if ({tpid[d], taddr[d], tendp[d]} !== 15'd0) begin
        bad++;
        $display("FAIL rst_mid_fields dut%0d got %h want 0", d, {tpid[d], taddr[d], tendp[d]});
      end
    end
    repeat (20) @(negedge clk);
    send_good(4'b1001, 7'd33, 4'h6, 1'b1);
    idle_bus();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send_good(4'b1101, 7'd5, 4'h1, 1'b1);
    send_good(4'b0001, 7'd77, 4'hF, 1'b1);
    idle_bus();
    wait_drain();
    total++;
    if (v_cyc_last - v_cyc_prev != 20) begin
      bad++;
      $display("FAIL b2b_spacing got %0d cycles want 20", v_cyc_last - v_cyc_prev);
    end
  endtask

  task automatic test_random();
    logic [3:0] pids [4];
    logic [3:0] p;
    logic [6:0] a;
    pids[0] = 4'b0001; pids[1] = 4'b1001; pids[2] = 4'b1101; pids[3] = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      p = pids[$urandom_range(0, 3)];
      a = ($urandom_range(0, 1) == 0) ? 7'd5 : 7'($urandom_range(0, 127));
      send_good(p, a, 4'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 1) == 0) begin
        idle_bus();
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    idle_bus();
    wait_drain();
  endtask

  initial begin
    pend_fields = 1'b0;
    v_cyc_prev = 0;
    v_cyc_last = 0;
    for (int d = 0; d < 2; d++) begin
      fexp_pid[d] = 4'd0; fexp_addr[d] = 7'd0; fexp_endp[d] = 4'd0;
    end
    test_reset();
    fork
      monitor();
    join_none
    test_setup();
    test_crc_err();
    test_pid_err();
    test_filter();
    test_malformed();
    test_rst_mid_crc();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
